sr04_trigger_ctrl: RTL and testbench
====================================

SR04_TRIGGER_CTRL -- requirements
Module: sr04_trigger_ctrl

Interface
REQ-001 Parameter TRIG_US, default 10: trigger pulse length in i_tick periods.
REQ-002 Parameter ECHO_WAIT_US, default 30000: maximum wait from trigger end to echo rise.
REQ-003 Parameter ECHO_MAX_US, default 38000: maximum echo-high duration.
REQ-004 Parameter HOLDOFF_US, default 50000: quiet time after each measurement before the next one is accepted.
REQ-005 clk  input  1  system clock; the only clock in the block.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 i_tick  input  1  1 us strobe, one clk wide.
REQ-008 start  input  1  measurement request pulse.
REQ-009 echo  input  1  raw SR04 echo pin, asynchronous to clk.
REQ-010 dist_done  input  1  done pulse from the downstream distance calculator.
REQ-011 trig  output  1  SR04 trigger pin drive.
REQ-012 echo_s  output  1  2-FF synchronised echo, fed to the distance calculator.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout  output  1  one-clk pulse when a measurement is aborted.
REQ-015 meas_ok  output  1  one-clk pulse when a measurement completes normally.

Function
REQ-016 The block SHALL synchronise echo through two flops; all echo decisions use echo_s, so there is 2 clk of latency from the pin.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE and HOLDOFF, with a 16-bit tick counter that is cleared on every state entry and increments on i_tick.
REQ-018 IDLE: on start=1, go to TRIG on the next clk; trig SHALL rise in that same clk.
REQ-019 TRIG: trig=1; on the i_tick that brings the counter to TRIG_US, go to WAIT_ECHO with trig=0.
REQ-020 WAIT_ECHO: on an echo_s low-to-high edge, go to MEASURE; echo_s already high on entry SHALL NOT count as an edge.
REQ-021 WAIT_ECHO: if the counter reaches ECHO_WAIT_US first, pulse timeout and go to HOLDOFF.
REQ-022 MEASURE: on echo_s=0 or dist_done=1, pulse meas_ok and go to HOLDOFF.
REQ-023 MEASURE: if the counter reaches ECHO_MAX_US first, pulse timeout and go to HOLDOFF.
REQ-024 MEASURE: if the echo fall and the limit happen in the same clk, meas_ok SHALL win; timeout and meas_ok are never high together.
REQ-025 HOLDOFF: when the counter reaches HOLDOFF_US, go to IDLE.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 start coincident with i_tick SHALL behave the same as start alone.
REQ-028 The counter SHALL saturate and never wrap; every limit must be at most 65535.
REQ-029 trig SHALL be high only in TRIG and is driven from a register, so it is glitch-free.

Reset
REQ-030 On rst=1 at a clk edge, the block SHALL enter IDLE and clear the counter, both synchroniser flops, trig, busy, timeout and meas_ok.
REQ-031 rst mid-measurement (any state) SHALL force trig=0 within one clk and emit no timeout or meas_ok pulse.
REQ-032 The first start SHALL be accepted on the first clk after rst deasserts.

Configuration
REQ-033 Macro SR04_AUTO_TRIG_EN defined: in IDLE the block SHALL self-start exactly as if start=1, giving continuous measurements with a period of at least TRIG_US+HOLDOFF_US ticks; start is then don't-care.
REQ-034 Macro SR04_AUTO_TRIG_EN undefined: measurements SHALL start only on start.

Verification
REQ-035 start pulse, echo rises 500 us after trig falls and stays high 1160 us -> trig high exactly 10 ticks; meas_ok pulses 2 clk after echo falls; busy drops 50000 ticks later.
REQ-036 start, echo never rises -> timeout pulses at WAIT_ECHO tick 30000; meas_ok never pulses; the block returns to IDLE after a further 50000 ticks.
REQ-037 echo stuck high for 40000 us -> timeout pulses at MEASURE tick 38000.
REQ-038 second start during HOLDOFF -> ignored; no trig until the next start after busy=0.
REQ-039 rst asserted at TRIG tick 5 -> trig=0 on the next clk, state IDLE, no pulses.
REQ-040 SR04_AUTO_TRIG_EN defined, start tied 0, echo absent -> trig pulses repeat every 80010 ticks (10 + 30000 + 50000) with timeout each cycle.

Source files
------------

// File: rtl/sr04_trigger_ctrl.sv
// sr04_trigger_ctrl: HC-SR04 ultrasonic ranger sequencer.
// Fires a trigger pulse, waits for the echo to rise, times the echo-high
// window, then enforces a quiet holdoff before the next measurement.
// Build option: define SR04_AUTO_TRIG_EN to make the block re-trigger by itself
// whenever it is idle (start is then ignored).
// All limits are counted in i_tick periods and must fit in 16 bits (<= 65535).
module sr04_trigger_ctrl #(
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned ECHO_WAIT_US = 30000,
  parameter int unsigned ECHO_MAX_US  = 38000,
  parameter int unsigned HOLDOFF_US   = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic start,
  input  logic echo,
  input  logic dist_done,
  output logic trig,
  output logic echo_s,
  output logic busy,
  output logic timeout,
  output logic meas_ok
);

  localparam logic [15:0] TRIG_LIM = TRIG_US[15:0];
  localparam logic [15:0] WAIT_LIM = ECHO_WAIT_US[15:0];
  localparam logic [15:0] MAX_LIM  = ECHO_MAX_US[15:0];
  localparam logic [15:0] HOLD_LIM = HOLDOFF_US[15:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        echo_meta_q, echo_meta_d;
  logic        echo_sync_q, echo_sync_d;
  logic        armed_q, armed_d;
  logic        trig_q, trig_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic        meas_ok_q, meas_ok_d;
  logic        go;

`ifdef SR04_AUTO_TRIG_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    timeout_d   = 1'b0;
    meas_ok_d   = 1'b0;
    echo_meta_d = echo;
    echo_sync_d = echo_meta_q;

    // Saturating tick counter: value as it will be after this clk's tick.
    cnt_inc = cnt_q;
    if (i_tick && (cnt_q != 16'hFFFF)) begin
      cnt_inc = cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (i_tick && (cnt_inc >= TRIG_LIM)) begin
          state_d = S_WAIT_ECHO;
        end
      end
      S_WAIT_ECHO: begin
        // A rise only counts once echo_s has been seen low inside this state.
        if (armed_q && echo_sync_q) begin
          state_d = S_MEASURE;
        end else if (cnt_inc >= WAIT_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_HOLDOFF;
        end
      end
      S_MEASURE: begin
        // Normal completion outranks the limit when both land in one clk.
        if (!echo_sync_q || dist_done) begin
          meas_ok_d = 1'b1;
          state_d   = S_HOLDOFF;
        end else if (cnt_inc >= MAX_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (cnt_inc >= HOLD_LIM) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cnt_d   = (state_d != state_q) ? 16'd0 : cnt_inc;
    armed_d = (state_q == S_WAIT_ECHO) && (state_d == S_WAIT_ECHO) &&
              (armed_q || !echo_sync_q);
    trig_d  = (state_d == S_TRIG);
    busy_d  = (state_d != S_IDLE);
  end

  // State, counter, echo synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      armed_q     <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      meas_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      echo_meta_q <= echo_meta_d;
      echo_sync_q <= echo_sync_d;
      armed_q     <= armed_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      meas_ok_q   <= meas_ok_d;
    end
  end

  assign trig    = trig_q;
  assign echo_s  = echo_sync_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign meas_ok = meas_ok_q;

endmodule

// File: tb/tb_sr04_trigger_ctrl.sv
// Testbench for sr04_trigger_ctrl with shortened limits and a 1-in-4 tick.
// A timeline model of one measurement runs alongside the DUT and is compared
// every clk; directed scenarios add hand-computed tick/latency expectations.
`timescale 1ns/1ps
module tb_sr04_trigger_ctrl;

  localparam int TRIG_US      = 10;
  localparam int ECHO_WAIT_US = 300;
  localparam int ECHO_MAX_US  = 380;
  localparam int HOLDOFF_US   = 500;
  localparam int TICK_DIV     = 4;
`ifdef SR04_AUTO_TRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, i_tick, start, echo, dist_done;
  logic trig, echo_s, busy, timeout, meas_ok;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tk      = 0;
  bit chk_en  = 1'b0;

  // model outputs and sampled inputs
  logic m_trig = 1'b0, m_es = 1'b0, m_busy = 1'b0, m_to = 1'b0, m_ok = 1'b0;
  logic es1 = 1'b0, es2 = 1'b0;
  bit   s_rst, s_tick, s_start, s_dd, s_es;

  sr04_trigger_ctrl #(
    .TRIG_US      (TRIG_US),
    .ECHO_WAIT_US (ECHO_WAIT_US),
    .ECHO_MAX_US  (ECHO_MAX_US),
    .HOLDOFF_US   (HOLDOFF_US)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_tick    (i_tick),
    .start     (start),
    .echo      (echo),
    .dist_done (dist_done),
    .trig      (trig),
    .echo_s    (echo_s),
    .busy      (busy),
    .timeout   (timeout),
    .meas_ok   (meas_ok)
  );

  always #5 clk = ~clk;

  // 1 us strobe: one clk high out of every TICK_DIV
  initial begin
    int div;
    div    = 0;
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      i_tick = (div == TICK_DIV - 1);
      div    = (div == TICK_DIV - 1) ? 0 : div + 1;
    end
  end

  // clk and tick counters as the DUT sees them
  initial forever begin
    @(posedge clk);
    cyc++;
    if (i_tick) tk++;
  end

  // One clk edge of the model: sample inputs, age the echo delay line.
  task automatic step(output bit ab);
    @(posedge clk);
    s_rst   = rst;
    s_tick  = i_tick;
    s_start = start;
    s_dd    = dist_done;
    s_es    = es2;
    m_to    = 1'b0;
    m_ok    = 1'b0;
    if (rst) begin
      es1 = 1'b0; es2 = 1'b0; m_trig = 1'b0; m_busy = 1'b0;
    end else begin
      es2 = es1; es1 = echo;
    end
    m_es = es2;
    ab   = s_rst;
  endtask

  // Timeline of one measurement, restarted from idle whenever rst is seen.
  initial begin : model
    bit ab;
    int n;
    int res;
    bit prev, have_prev;
    forever begin
      m_trig = 1'b0;
      m_busy = 1'b0;
      forever begin
        step(ab);
        if (!ab && (s_start || AUTO)) break;
      end
      m_trig = 1'b1;
      m_busy = 1'b1;
      n = 0;
      ab = 1'b0;
      while (n < TRIG_US) begin
        step(ab);
        if (ab) break;
        if (s_tick) n++;
      end
      if (ab) continue;
      m_trig = 1'b0;
      n = 0; res = 0; prev = 1'b0; have_prev = 1'b0;
      while (res == 0) begin
        step(ab);
        if (ab) break;
        if (have_prev && !prev && s_es) res = 1;
        else begin
          if (s_tick) n++;
          if (n >= ECHO_WAIT_US) res = 2;
        end
        prev = s_es;
        have_prev = 1'b1;
      end
      if (ab) continue;
      if (res == 2) m_to = 1'b1;
      else begin
        n = 0; res = 0;
        while (res == 0) begin
          step(ab);
          if (ab) break;
          if (!s_es || s_dd) res = 1;
          else begin
            if (s_tick) n++;
            if (n >= ECHO_MAX_US) res = 2;
          end
        end
        if (ab) continue;
        if (res == 1) m_ok = 1'b1;
        else m_to = 1'b1;
      end
      n = 0;
      while (n < HOLDOFF_US) begin
        step(ab);
        if (ab) break;
        if (s_tick) n++;
      end
    end
  end

  // every-clk comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_tests++;
      if ({trig, echo_s, busy, timeout, meas_ok} !== {m_trig, m_es, m_busy, m_to, m_ok}) begin
        n_fail++;
        $display("FAIL model_cmp cyc %0d: dut trig,echo_s,busy,timeout,meas_ok=%b%b%b%b%b model=%b%b%b%b%b",
                 cyc, trig, echo_s, busy, timeout, meas_ok, m_trig, m_es, m_busy, m_to, m_ok);
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0:       return trig;
      1:       return busy;
      2:       return timeout;
      default: return meas_ok;
    endcase
  endfunction

  // Wait (bounded) for an output to take a value; returns clks/ticks elapsed.
  task automatic wait_out(input string name, input int sel, input logic val,
                          input int budget, output int clks, output int tks);
    int c0, t0;
    bit hit;
    c0 = cyc; t0 = tk; hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (get_out(sel) === val) begin
        hit = 1'b1;
        break;
      end
    end
    clks = cyc - c0;
    tks  = tk - t0;
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no %b within %0d clks", name, val, budget);
    end
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tk;
    while (tk - t0 < n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int clks, tks, t_ref, t_echo;
    rst = 1'b1; start = 1'b0; echo = 1'b1; dist_done = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_trig", trig, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_timeout", timeout, 1'b0);
    check_bit("reset_meas_ok", meas_ok, 1'b0);
    check_bit("reset_echo_s", echo_s, 1'b0);
    chk_en = 1'b1;
    #1;
    echo = 1'b0;
`ifndef SR04_AUTO_TRIG_EN
    // normal measurement, start on the first clk after reset release
    rst = 1'b0;
    pulse_start();
    check_bit("first_start_trig", trig, 1'b1);
    check_bit("first_start_busy", busy, 1'b1);
    wait_out("trig_fall", 0, 1'b0, 100, clks, tks);
    check_int("trig_ticks", tks, 10);
    wait_ticks(50);
    echo = 1'b1;
    wait_ticks(116);
    echo = 1'b0;
    wait_out("meas_ok", 3, 1'b1, 20, clks, tks);
    check_int("meas_ok_latency", clks - 1, 2);
    wait_out("busy_drop", 1, 1'b0, HOLDOFF_US * TICK_DIV + 20, clks, tks);
    check_int("holdoff_ticks", tks, 500);

    // no echo at all
    pulse_start();
    check_bit("noecho_trig", trig, 1'b1);
    wait_out("noecho_trig_fall", 0, 1'b0, 100, clks, tks);
    wait_out("echo_wait_timeout", 2, 1'b1, ECHO_WAIT_US * TICK_DIV + 20, clks, tks);
    check_int("echo_wait_ticks", tks, 300);
    wait_out("noecho_busy_drop", 1, 1'b0, HOLDOFF_US * TICK_DIV + 20, clks, tks);
    check_int("noecho_holdoff_ticks", tks, 500);

    // echo stuck high
    pulse_start();
    wait_out("stuck_trig_fall", 0, 1'b0, 100, clks, tks);
    t_ref = tk;
    wait_ticks(20);
    echo = 1'b1;
    wait_out("meas_timeout", 2, 1'b1, 400 * TICK_DIV + 40, clks, tks);
    check_int("meas_timeout_ticks", tk - t_ref, 400);
    wait_ticks(20);
    echo = 1'b0;
    wait_out("stuck_busy_drop", 1, 1'b0, HOLDOFF_US * TICK_DIV + 20, clks, tks);

    // dist_done ends the measurement; a start during holdoff is dropped
    pulse_start();
    wait_out("dd_trig_fall", 0, 1'b0, 100, clks, tks);
    wait_ticks(10);
    echo = 1'b1;
    wait_ticks(30);
    dist_done = 1'b1;
    @(negedge clk);
    #1;
    dist_done = 1'b0;
    check_bit("dist_done_meas_ok", meas_ok, 1'b1);
    echo = 1'b0;
    wait_ticks(100);
    pulse_start();
    check_bit("holdoff_start_ignored", trig, 1'b0);
    wait_out("dd_busy_drop", 1, 1'b0, HOLDOFF_US * TICK_DIV + 20, clks, tks);
    repeat (8) @(negedge clk);
    #1;
    check_bit("no_queued_trig", trig, 1'b0);

    // start coincident with a tick, then reset at TRIG tick 5
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      if (i_tick) break;
      @(negedge clk);
      #1;
    end
    pulse_start();
    check_bit("start_on_tick_trig", trig, 1'b1);
    wait_ticks(5);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_bit("rst_trig", trig, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_timeout", timeout, 1'b0);
    check_bit("rst_meas_ok", meas_ok, 1'b0);
    rst = 1'b0;
    pulse_start();
    check_bit("restart_trig", trig, 1'b1);

    // echo already high when the wait starts must not count as a rise
    echo = 1'b1;
    wait_out("hi_trig_fall", 0, 1'b0, 100, clks, tks);
    t_ref = tk;
    wait_ticks(30);
    echo = 1'b0;
    wait_ticks(10);
    echo = 1'b1;
    wait_ticks(40);
    echo = 1'b0;
    wait_out("rearm_meas_ok", 3, 1'b1, 20, clks, tks);
    check_int("rearm_ticks", tk - t_ref, 80);
    wait_out("hi_busy_drop", 1, 1'b0, HOLDOFF_US * TICK_DIV + 20, clks, tks);

    // echo fall and the echo-high limit in the same clk
    pulse_start();
    wait_out("tie_trig_fall", 0, 1'b0, 100, clks, tks);
    wait_ticks(20);
    echo = 1'b1;
    t_echo = tk;
    wait_ticks(379);
    @(negedge clk);
    #1;
    echo = 1'b0;
    wait_out("tie_meas_ok", 3, 1'b1, 10, clks, tks);
    check_bit("tie_no_timeout", timeout, 1'b0);
    check_int("tie_ticks", tk - t_echo, 380);
    wait_out("tie_busy_drop", 1, 1'b0, HOLDOFF_US * TICK_DIV + 20, clks, tks);
`else
    // free-running: period is trigger + echo wait + holdoff ticks
    rst = 1'b0;
    wait_out("auto_first_trig", 0, 1'b1, 5, clks, tks);
    for (int k = 0; k < 2; k++) begin
      t_ref = tk;
      wait_out("auto_trig_fall", 0, 1'b0, 100, clks, tks);
      check_int("auto_trig_ticks", tks, 10);
      wait_out("auto_timeout", 2, 1'b1, ECHO_WAIT_US * TICK_DIV + 20, clks, tks);
      wait_out("auto_next_trig", 0, 1'b1, HOLDOFF_US * TICK_DIV + 20, clks, tks);
      check_int("auto_period_ticks", tk - t_ref, 810);
    end
    t_echo = 0;
`endif
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
